seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-bus seven-segment display. It holds a DIGITS-wide hex value and drives one digit select at a time. A single shared hex-to-segment decoder (`semisegment`) is instantiated internally and driven by the currently selected nibble. Dead time between slots suppresses ghosting, leading zeros can be blanked, and new values are committed only at frame boundaries so the display never tears.

## Interface
- DIGITS, 4: number of digits; legal range 1–8.
- PRESCALE, 50000: clock cycles per digit slot; must be greater than DEAD.
- DEAD, 4: dark cycles at the start of each slot; must be at least 0.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  hex value to show; nibble i maps to digit i, with digit 0 least significant.
- dp_in  in  DIGITS  decimal-point enables, one per digit.
- lz_in  in  1  leading-zero suppression enable.
- load  in  1  one-cycle strobe that captures value, dp_in and lz_in into the shadow registers.
- digit_en  out  DIGITS  one-hot digit select, active high; all zero during dead time.
- seg  out  7  segment pattern with bit0=a … bit6=g, active high; all zero when dark or blanked.
- dp  out  1  decimal point for the lit digit.
- pending  out  1  shadow holds a value not yet committed.
- frame  out  1  one-cycle pulse at each commit point.

## Operation
- Registers:
  - Prescale counter `cnt` runs 0..PRESCALE-1.
  - Digit index `idx` runs 0..DIGITS-1.
  - Shadow registers: `sh_val`, `sh_dp`, `sh_lz`.
  - Committed registers: `cm_val`, `cm_dp`, `cm_lz`.
  - Flag `pending`.
- Two-state slot FSM:
  - DARK while `cnt` < DEAD: `digit_en`=0, `seg`=0, `dp`=0.
  - LIT while `cnt` ≥ DEAD: `digit_en`=1<<idx, `seg`=decode(`cm_val[idx]`), `dp`=`cm_dp[idx]`.
  - When DEAD=0, DARK is never entered.
- Slot end (`cnt`=PRESCALE-1): `cnt`←0 and `idx`←`idx`+1.
- Wrap (`idx` goes from DIGITS-1 to 0) is the commit point:
  - If `pending`=1: committed registers ← shadow, and `pending`←0.
  - `frame` pulses whether or not a commit happens.
- Load:
  - `load`=1 writes the shadow registers and sets `pending`←1.
  - A second load while pending overwrites the shadow; last write wins.
- Load on the commit edge: the loaded data bypasses the shadow straight into the committed registers, and `pending` is 0 afterwards.
- Leading-zero suppression, when `cm_lz`=1:
  - Digit i is blanked if nibbles DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked.
  - A blanked digit still asserts `digit_en`, with `seg`=0 and `dp`=`cm_dp[i]`.
- Decoder map, hex nibble → `seg` (bit6..bit0):
  - 0 → 0111111, 1 → 0000110, 2 → 1011011, 3 → 1001111
  - 4 → 1100110, 5 → 1101101, 6 → 1111101, 7 → 0000111
  - 8 → 1111111, 9 → 1101111, A → 1110111, B → 1111100
  - C → 0111001, D → 1011110, E → 1111001, F → 1110001
- Reset values: every register and every output is 0, including `idx`, `cnt`, committed and shadow values, `pending` and `frame`. After reset release the display shows 0 on all digits, or only digit 0 if `lz` is later enabled and the value is 0.
- `rst` asserted mid-slot or mid-pending: the outputs go dark immediately (asynchronously), and any pending value is discarded.

## Timing
- All outputs are registered and decoded from next-state.
- Output timing from reset release:
  - `digit_en[0]` rises on rising edge number DEAD after `rst` falls, and stays high for PRESCALE-DEAD cycles.
  - `digit_en[1]` rises PRESCALE cycles after `digit_en[0]`.
- Frame period is DIGITS*PRESCALE cycles.
- `frame` is high for the single cycle following the wrap edge.
- `pending` rises the cycle after `load` is sampled.
- Load-to-display latency: from 1 to DIGITS*PRESCALE cycles, ending at the next wrap.
- `digit_en` is never multi-hot in any cycle.
- `seg` and `digit_en` change on the same edge.

## Test plan
- Reset/scan, DIGITS=4, PRESCALE=8, DEAD=2: release `rst`; verify `digit_en` walks 0001→0010→0100→1000 with 6 lit and 2 dark cycles each, `seg`=0111111, and `frame` every 32 cycles.
- Value display: load `value`=16'h1A3F, `dp_in`=4'b0100, `lz_in`=0; after the next `frame` verify:
  - digit0 `seg`=1110001
  - digit1 `seg`=1001111
  - digit2 `seg`=1110111 with `dp`=1
  - digit3 `seg`=0000110
- No tearing: load 16'h1111 mid-frame and then 16'h2222 before the wrap; verify `pending`=1 until the wrap, no 1111 is ever displayed, and all digits show 1011011 afterwards.
- Leading zeros: load 16'h0005 with `lz_in`=1; verify digits 3–1 show `seg`=0 with `digit_en` still asserted and digit0=1101101. Load 16'h0000 and verify only digit0 shows 0111111.
- Commit-edge load: pulse `load`=16'h7777 exactly on the wrap edge; verify `pending` stays 0 and the very next frame shows 0000111 on all digits.
- Mid-operation reset: assert `rst` during a LIT cycle with `pending`=1; verify `digit_en`, `seg` and `dp` are 0 immediately. After release, verify the display shows 0000 and the pending value never appears.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-bus seven-segment display.
// Values are committed only at frame wrap so a frame never shows mixed data.

module semisegment (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    case (nibble_i)
      4'h0: seg_o = 7'b0111111;
      4'h1: seg_o = 7'b0000110;
      4'h2: seg_o = 7'b1011011;
      4'h3: seg_o = 7'b1001111;
      4'h4: seg_o = 7'b1100110;
      4'h5: seg_o = 7'b1101101;
      4'h6: seg_o = 7'b1111101;
      4'h7: seg_o = 7'b0000111;
      4'h8: seg_o = 7'b1111111;
      4'h9: seg_o = 7'b1101111;
      4'hA: seg_o = 7'b1110111;
      4'hB: seg_o = 7'b1111100;
      4'hC: seg_o = 7'b0111001;
      4'hD: seg_o = 7'b1011110;
      4'hE: seg_o = 7'b1111001;
      4'hF: seg_o = 7'b1110001;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  lz_i,
  input  logic                  load_i,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  pending_o,
  output logic                  frame_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CntLast = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IdxLast = IW'(DIGITS - 1);

  localparam logic SlotDark = 1'b0;
  localparam logic SlotLit  = 1'b1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d, cm_val_q, cm_val_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, cm_dp_q, cm_dp_d;
  logic                sh_lz_q, sh_lz_d, cm_lz_q, cm_lz_d;
  logic                pending_q, pending_d;
  logic                frame_q, frame_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                slot_end, wrap;
  logic                slot_d;
  logic [DIGITS-1:0]   blank;
  logic                all_zero;
  logic [3:0]          nibble_sel;
  logic                dp_sel;
  logic                blank_sel;
  logic [6:0]          dec_seg;

  assign slot_end = (cnt_q == CntLast);
  assign wrap     = slot_end && (idx_q == IdxLast);

  // Scan counters, shadow/commit handshake and the frame pulse.
  always_comb begin
    cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
    end

    sh_val_d  = load_i ? value_i : sh_val_q;
    sh_dp_d   = load_i ? dp_i    : sh_dp_q;
    sh_lz_d   = load_i ? lz_i    : sh_lz_q;

    cm_val_d  = cm_val_q;
    cm_dp_d   = cm_dp_q;
    cm_lz_d   = cm_lz_q;
    pending_d = pending_q;
    frame_d   = wrap;

    if (wrap) begin
      // A load landing exactly on the wrap edge goes straight to the display.
      if (load_i) begin
        cm_val_d = value_i;
        cm_dp_d  = dp_i;
        cm_lz_d  = lz_i;
      end else if (pending_q) begin
        cm_val_d = sh_val_q;
        cm_dp_d  = sh_dp_q;
        cm_lz_d  = sh_lz_q;
      end
      pending_d = 1'b0;
    end else if (load_i) begin
      pending_d = 1'b1;
    end
  end

  generate
    if (DEAD == 0) begin : g_no_dead
      assign slot_d = SlotLit;
    end else begin : g_dead
      assign slot_d = (cnt_d >= CW'(DEAD)) ? SlotLit : SlotDark;
    end
  endgenerate

  // Blank digit i when every nibble from the top down to i is zero; digit 0 always shows.
  always_comb begin
    blank    = '0;
    all_zero = cm_lz_d;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (cm_val_d[4*i +: 4] == 4'h0);
      blank[i] = all_zero;
    end
  end

  always_comb begin
    nibble_sel = 4'h0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nibble_sel = cm_val_d[4*i +: 4];
        dp_sel     = cm_dp_d[i];
        blank_sel  = blank[i];
      end
    end
  end

  semisegment u_dec (
    .nibble_i (nibble_sel),
    .seg_o    (dec_seg)
  );

  always_comb begin
    digit_en_d = '0;
    seg_d      = 7'b0000000;
    dp_d       = 1'b0;
    if (slot_d == SlotLit) begin
      digit_en_d = DIGITS'(1) << idx_d;
      seg_d      = blank_sel ? 7'b0000000 : dec_seg;
      dp_d       = dp_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      sh_lz_q    <= 1'b0;
      cm_val_q   <= '0;
      cm_dp_q    <= '0;
      cm_lz_q    <= 1'b0;
      pending_q  <= 1'b0;
      frame_q    <= 1'b0;
      digit_en_q <= '0;
      seg_q      <= 7'b0000000;
      dp_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      sh_lz_q    <= sh_lz_d;
      cm_val_q   <= cm_val_d;
      cm_dp_q    <= cm_dp_d;
      cm_lz_q    <= cm_lz_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
      digit_en_q <= digit_en_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign digit_en_o = digit_en_q;
  assign seg_o      = seg_q;
  assign dp_o       = dp_q;
  assign pending_o  = pending_q;
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads, each cycle
// compared against a time-based model of the scan and commit behaviour.

module tb_seg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int DEAD     = 2;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [4*DIGITS-1:0] value = '0;
  logic [DIGITS-1:0]   dpIn = '0;
  logic                lzIn = 1'b0;
  logic                load = 1'b0;
  logic [DIGITS-1:0]   digitEn;
  logic [6:0]          seg;
  logic                dp;
  logic                pending;
  logic                frame;

  int testsRun  = 0;
  int failCount = 0;

  // Reference state: edges since reset release plus shadow/committed contents.
  int          n;
  logic [15:0] shVal, cmVal;
  logic [3:0]  shDp, cmDp;
  logic        shLz, cmLz, pend, frm;
  logic [6:0]  segTable [16];

  seg_scan_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .DEAD     (DEAD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value),
    .dp_i       (dpIn),
    .lz_i       (lzIn),
    .load_i     (load),
    .digit_en_o (digitEn),
    .seg_o      (seg),
    .dp_o       (dp),
    .pending_o  (pending),
    .frame_o    (frame)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic modelReset();
    n     = 0;
    shVal = '0; cmVal = '0;
    shDp  = '0; cmDp  = '0;
    shLz  = 1'b0; cmLz = 1'b0;
    pend  = 1'b0; frm  = 1'b0;
  endtask

  task automatic checkModel();
    int          pos, d;
    logic        lit, blanked;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [3:0]  expEn;
    logic [6:0]  expSeg;
    logic        expDp;
    pos     = n % PRESCALE;
    d       = (n / PRESCALE) % DIGITS;
    lit     = (pos >= DEAD);
    upper   = cmVal >> (4 * d);
    nib     = upper[3:0];
    blanked = cmLz && (d != 0) && (upper == 16'h0);
    expEn   = lit ? 4'(1 << d) : 4'b0000;
    expSeg  = (lit && !blanked) ? segTable[nib] : 7'b0000000;
    expDp   = lit ? cmDp[d] : 1'b0;
    checkOutput("digit_en", 32'(digitEn), 32'(expEn));
    checkOutput("seg",      32'(seg),     32'(expSeg));
    checkOutput("dp",       32'(dp),      32'(expDp));
    checkOutput("pending",  32'(pending), 32'(pend));
    checkOutput("frame",    32'(frame),   32'(frm));
  endtask

  // One clock edge with the given inputs, then model update and comparison.
  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] dpv, input logic lz);
    load  = ld;
    value = v;
    dpIn  = dpv;
    lzIn  = lz;
    @(posedge clk);
    #1;
    n++;
    frm = (n % FRAME == 0);
    if (frm) begin
      if (ld) begin
        cmVal = v; cmDp = dpv; cmLz = lz;
      end else if (pend) begin
        cmVal = shVal; cmDp = shDp; cmLz = shLz;
      end
      pend = 1'b0;
    end else if (ld) begin
      pend = 1'b1;
    end
    if (ld) begin
      shVal = v; shDp = dpv; shLz = lz;
    end
    checkModel();
    load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    segTable = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    modelReset();

    // Reset state
    #1;
    checkOutput("rst_digit_en", 32'(digitEn), 32'h0);
    checkOutput("rst_seg",      32'(seg),     32'h0);
    checkOutput("rst_pending",  32'(pending), 32'h0);
    checkOutput("rst_frame",    32'(frame),   32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle scan over two frames showing 0000
    idle(2 * FRAME);

    // Value display: 1A3F with dp on digit 2
    idle(5);
    applyStimulus(1'b1, 16'h1A3F, 4'b0100, 1'b0);
    idle(2 * FRAME);

    // No tearing: two loads in the same frame, last one wins
    idle(3);
    applyStimulus(1'b1, 16'h1111, 4'b0000, 1'b0);
    idle(6);
    applyStimulus(1'b1, 16'h2222, 4'b0000, 1'b0);
    idle(2 * FRAME);

    // Leading-zero suppression
    applyStimulus(1'b1, 16'h0005, 4'b0000, 1'b1);
    idle(2 * FRAME);
    applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b1);
    idle(2 * FRAME);

    // Load landing exactly on the wrap edge
    for (int i = 0; i < FRAME && ((n + 1) % FRAME != 0); i++) idle(1);
    applyStimulus(1'b1, 16'h7777, 4'b0000, 1'b0);
    checkOutput("commit_edge_pending", 32'(pending), 32'h0);
    idle(FRAME + 2);

    // Mid-operation reset with a pending value in a lit cycle
    for (int i = 0; i < FRAME && (n % FRAME != 4); i++) idle(1);
    applyStimulus(1'b1, 16'h9999, 4'b1111, 1'b0);
    for (int i = 0; i < PRESCALE && (n % PRESCALE < DEAD); i++) idle(1);
    checkOutput("pre_rst_pending", 32'(pending), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_digit_en", 32'(digitEn), 32'h0);
    checkOutput("async_rst_seg",      32'(seg),     32'h0);
    checkOutput("async_rst_dp",       32'(dp),      32'h0);
    checkOutput("async_rst_pending",  32'(pending), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    idle(2 * FRAME);

    // Randomized loads
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        applyStimulus(1'b1, 16'($urandom), 4'($urandom), 1'($urandom));
      else
        idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
